cart_dongle_sched: RTL
======================

Name: cart_dongle_sched

Overview:
- Sequencer for the cartridge-port copy-protection dongle models (the ROM3 strobe, A8 and D8 path).
- Turns CPU ROM3 read requests into properly timed strobe cycles: rom3_n low, then a rising edge with A8 held.
- Samples D8 during the low phase and gives the CPU an ack.
- Holds off back-to-back accesses until the selected dongle has registered the edge.
- Owns the dongle power-on reset and selects which of NDONGLE dongle models drives D8.

Parameters:
- NDONGLE, 2: number of dongle models attached; sel index width is clog2(NDONGLE), minimum 1.
- POR_CYCLES, 16: cycles dongle_reset is held high after reset release or a dongle switch.
- LOW_CYCLES, 4: cycles rom3_n is held low per access; minimum 2.
- GAP_CYCLES, 3: cycles rom3_n is held high after the rising edge before the next access; minimum 2.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- cfg_enable, in, 1: dongle emulation enabled.
- cfg_sel, in, SW: selected dongle index.
- cpu_req, in, 1: level request, held until cpu_ack.
- cpu_a8, in, 1: address bit 8 of the ROM3 access.
- cpu_ack, out, 1: one-cycle completion pulse.
- cpu_d8, out, 1: read data, valid with cpu_ack and held until the next ack.
- dongle_rom3_n, out, 1: shared ROM3 strobe to all dongles.
- dongle_a8, out, 1: A8 to all dongles.
- dongle_reset, out, 1: active-high POR to all dongles.
- dongle_d8, in, NDONGLE: D8 outputs of each dongle.
- busy, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
Reset values:
- FSM = POR, counter = POR_CYCLES-1.
- dongle_rom3_n = 1, dongle_a8 = 0, dongle_reset = 1.
- cpu_ack = 0, cpu_d8 = 0, busy = 1.
- active_sel = 0.

State POR:
- dongle_reset = 1, rom3_n = 1.
- Counts down; at 0 goes to IDLE and dongle_reset drops the same edge.
- cpu_req is not acked during POR.

State IDLE:
- If a pending select exists (cfg_sel != active_sel), load active_sel = cfg_sel and go to POR. This has priority over cpu_req.
- Else if cpu_req = 1:
  - cfg_enable = 1: latch dongle_a8 = cpu_a8, drive rom3_n = 0 on the next edge, go to LOW with counter = LOW_CYCLES-1.
  - cfg_enable = 0: go to ACK with cpu_d8 = 0 and no strobe.

State LOW:
- rom3_n = 0, A8 stable.
- On the counter's last cycle, sample cpu_d8 <= dongle_d8[active_sel]. This is the value from the previous access state.
- Next: rom3_n = 1 (rising edge), go to GAP with counter = GAP_CYCLES-1.

State GAP:
- rom3_n = 1, A8 held until the counter expires.
- Then go to ACK.

State ACK:
- cpu_ack = 1 for exactly one cycle, then IDLE.
- A req still high in the following IDLE cycle starts a new access. Requesters must drop req the cycle after ack if they want one access only.

Access timing:
- Latency from req seen in IDLE to ack = LOW_CYCLES + GAP_CYCLES + 2 cycles (4+3+2 = 9 at defaults).
- Strobe period per access is at least LOW_CYCLES + GAP_CYCLES + 2.

Configuration changes:
- cfg_sel change mid-access is deferred until IDLE; it never truncates a strobe.
- cfg_enable dropping mid-access still completes the current strobe.
- cfg_sel out of range (>= NDONGLE): D8 reads as 0.

Other rules:
- reset_n asserted mid-access forces rom3_n = 1 and POR immediately (asynchronously).
- cpu_a8 changes during LOW/GAP are ignored.
- All outputs are registered.

Optional Feature:
DONGLE_ACCESS_COUNT_EN:
- When defined, adds output access_count[15:0], reset to 0.
- Increments by one on each rising rom3_n edge generated (LOW->GAP) and saturates at 16'hFFFF.
- Clears on any entry to POR.
- When undefined, the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, cfg_sel=0, req held high from time 0 -> dongle_reset high exactly 16 cycles; first rom3_n fall only after that; ack 9 cycles after IDLE.
- Single access a8=1, dongle_d8[0] forced 1 during LOW -> rom3_n low 4 cycles, dongle_a8=1 through GAP, cpu_d8=1 on ack; a single ack pulse.
- Back-to-back req held 3 accesses -> three strobes, each rising edge followed by at least 3 high cycles; 3 acks 9 cycles apart.
- cfg_sel 0->1 during LOW -> current access completes with dongle 0 data; then POR of 16 cycles; next access samples dongle_d8[1].
- cfg_enable=0, req -> ack after 1 cycle of IDLE, cpu_d8=0, rom3_n never low; reset_n pulsed during LOW -> rom3_n=1 immediately, dongle_reset=1.
- With DONGLE_ACCESS_COUNT_EN: 5 accesses -> access_count=5; a cfg_sel switch -> 0.

Source files
------------

// File: rtl/cart_dongle_sched_if.sv
// cart_dongle_sched_if: CPU request, configuration and dongle-side signals of the ROM3 sequencer.
// Optional DONGLE_ACCESS_COUNT_EN adds the access_count observation bus.
`default_nettype none

interface cart_dongle_sched_if #(
    parameter int NDONGLE = 2
);
    localparam int SW = (NDONGLE > 1) ? $clog2(NDONGLE) : 1;

    logic               cfg_enable;
    logic [SW-1:0]      cfg_sel;
    logic               cpu_req;
    logic               cpu_a8;
    logic               cpu_ack;
    logic               cpu_d8;
    logic               dongle_rom3_n;
    logic               dongle_a8;
    logic               dongle_reset;
    logic [NDONGLE-1:0] dongle_d8;
    logic               busy;
`ifdef DONGLE_ACCESS_COUNT_EN
    logic [15:0]        access_count;
`endif

    modport master (
        output cfg_enable, cfg_sel, cpu_req, cpu_a8, dongle_d8,
`ifdef DONGLE_ACCESS_COUNT_EN
        input  access_count,
`endif
        input  cpu_ack, cpu_d8, dongle_rom3_n, dongle_a8, dongle_reset, busy
    );

    modport slave (
        input  cfg_enable, cfg_sel, cpu_req, cpu_a8, dongle_d8,
`ifdef DONGLE_ACCESS_COUNT_EN
        output access_count,
`endif
        output cpu_ack, cpu_d8, dongle_rom3_n, dongle_a8, dongle_reset, busy
    );
endinterface

`default_nettype wire

// File: rtl/cart_dongle_sched.sv
// cart_dongle_sched: ROM3 strobe sequencer, dongle POR owner and D8 selector for copy-protection dongles.
// Optional DONGLE_ACCESS_COUNT_EN: saturating count of generated rom3_n rising edges.
`default_nettype none

module cart_dongle_sched #(
    parameter int NDONGLE    = 2,
    parameter int POR_CYCLES = 16,
    parameter int LOW_CYCLES = 4,
    parameter int GAP_CYCLES = 3
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    cart_dongle_sched_if.slave bus
);
    localparam int SW   = (NDONGLE > 1) ? $clog2(NDONGLE) : 1;
    localparam int MAXA = (POR_CYCLES > LOW_CYCLES) ? POR_CYCLES : LOW_CYCLES;
    localparam int MAXC = (MAXA > GAP_CYCLES) ? MAXA : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        S_POR  = 3'd0,
        S_IDLE = 3'd1,
        S_LOW  = 3'd2,
        S_GAP  = 3'd3,
        S_ACK  = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] active_sel_q;
    logic          rom3_n_q;
    logic          a8_q;
    logic          dongle_reset_q;
    logic          cpu_ack_q;
    logic          cpu_d8_q;
    logic          d8_smp_q;
    logic          busy_q;
    logic          sel_d8;

    // Out-of-range selections fall through to 0.
    always_comb begin
        sel_d8 = 1'b0;
        for (int i = 0; i < NDONGLE; i++) begin
            if (active_sel_q == SW'(i)) sel_d8 = bus.dongle_d8[i];
        end
    end

`ifdef DONGLE_ACCESS_COUNT_EN
    logic [15:0] access_count_q;
    logic [15:0] access_count_d;
    assign access_count_d   = (access_count_q == 16'hFFFF) ? access_count_q : access_count_q + 16'd1;
    assign bus.access_count = access_count_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_POR;
            cnt_q          <= CW'(POR_CYCLES - 1);
            active_sel_q   <= '0;
            rom3_n_q       <= 1'b1;
            a8_q           <= 1'b0;
            dongle_reset_q <= 1'b1;
            cpu_ack_q      <= 1'b0;
            cpu_d8_q       <= 1'b0;
            d8_smp_q       <= 1'b0;
            busy_q         <= 1'b1;
`ifdef DONGLE_ACCESS_COUNT_EN
            access_count_q <= 16'd0;
`endif
        end else begin
            cpu_ack_q <= 1'b0;
            case (state_q)
                S_POR: begin
                    if (cnt_q == '0) begin
                        state_q        <= S_IDLE;
                        dongle_reset_q <= 1'b0;
                        busy_q         <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_IDLE: begin
                    // A pending dongle switch wins over a waiting request.
                    if (bus.cfg_sel != active_sel_q) begin
                        active_sel_q   <= bus.cfg_sel;
                        state_q        <= S_POR;
                        cnt_q          <= CW'(POR_CYCLES - 1);
                        dongle_reset_q <= 1'b1;
                        busy_q         <= 1'b1;
`ifdef DONGLE_ACCESS_COUNT_EN
                        access_count_q <= 16'd0;
`endif
                    end else if (bus.cpu_req) begin
                        busy_q <= 1'b1;
                        if (bus.cfg_enable) begin
                            a8_q     <= bus.cpu_a8;
                            rom3_n_q <= 1'b0;
                            state_q  <= S_LOW;
                            cnt_q    <= CW'(LOW_CYCLES - 1);
                        end else begin
                            state_q   <= S_ACK;
                            cpu_ack_q <= 1'b1;
                            cpu_d8_q  <= 1'b0;
                        end
                    end
                end
                S_LOW: begin
                    if (cnt_q == '0) begin
                        d8_smp_q <= sel_d8;
                        rom3_n_q <= 1'b1;
                        state_q  <= S_GAP;
                        cnt_q    <= CW'(GAP_CYCLES - 1);
`ifdef DONGLE_ACCESS_COUNT_EN
                        access_count_q <= access_count_d;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_q   <= S_ACK;
                        cpu_ack_q <= 1'b1;
                        cpu_d8_q  <= d8_smp_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q        <= S_POR;
                    cnt_q          <= CW'(POR_CYCLES - 1);
                    rom3_n_q       <= 1'b1;
                    dongle_reset_q <= 1'b1;
                    busy_q         <= 1'b1;
                end
            endcase
        end
    end

    assign bus.dongle_rom3_n = rom3_n_q;
    assign bus.dongle_a8     = a8_q;
    assign bus.dongle_reset  = dongle_reset_q;
    assign bus.cpu_ack       = cpu_ack_q;
    assign bus.cpu_d8        = cpu_d8_q;
    assign bus.busy          = busy_q;

endmodule

`default_nettype wire
